hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall/flush controller for the 5-stage MIPS core.
- Consumes the decoded control that the pipeline carries per stage (regwrite/memtoreg/branch/jr/div flags plus register numbers).
- Produces the forwarding selects, the stall/flush enables that drive the pipeline registers (including flushE/stallE into the decode-side control pipeline), and the start/done handshake with the multi-cycle divider.
- Decision logic is combinational; the divider sequencing and its watchdog are sequential.

Parameters:
- DIV_MAX_CYCLES, 40, watchdog limit for cycles spent in BUSY before div_err is raised.
- CNT_W, 6, width of the watchdog counter; must satisfy 2^CNT_W > DIV_MAX_CYCLES.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- rsD, rtD  in  5  source register numbers in Decode.
- rsE, rtE  in  5  source register numbers in Execute.
- writeregE, writeregM, writeregW  in  5  destination register per stage.
- regwriteE, regwriteM, regwriteW  in  1  register-write enable per stage.
- memtoregE, memtoregM  in  1  load in stage.
- branchD, jrD  in  1  branch / jr in Decode.
- divE  in  1  divide instruction valid in Execute.
- div_done  in  1  divider result valid (single-cycle pulse).
- forwardaD, forwardbD  out  1  Decode comparator operand select; 1 = ALU result from M.
- forwardaE, forwardbE  out  2  ALU operand select; 00 = register file, 01 = W result, 10 = M result.
- stallF, stallD, stallE  out  1  hold the PC / IF-ID / ID-EX registers.
- flushE, flushM  out  1  insert a bubble into ID-EX / EX-MEM.
- div_start  out  1  one-cycle start pulse to the divider.
- div_busy  out  1  high in BUSY.
- div_err  out  1  sticky watchdog error.

Behaviour:
- Register $0 never matches for forwarding or stall: every compare also requires a nonzero register number.
- forwardaE:
  - 10 if regwriteM && writeregM == rsE.
  - Else 01 if regwriteW && writeregW == rsE.
  - Else 00.
  - M has priority over W.
- forwardbE: same rule as forwardaE, using rtE.
- forwardaD / forwardbD: regwriteM && writeregM == rsD / rtD.
- lwstall: memtoregE && (rtE == rsD || rtE == rtD).
- brstall: (branchD || jrD) && one of:
  - regwriteE && writeregE matches rsD (either) or rtD (branchD only).
  - memtoregM && writeregM matches the same operands.
- divstall: (state == IDLE && divE) || state == BUSY.
- stallF = stallD = lwstall | brstall | divstall.
- stallE = divstall.
- flushE = (lwstall | brstall) & ~divstall. ID-EX is never flushed while its instruction is held.
- flushM = divstall. A bubble enters MEM while EX is frozen.
- Divider FSM (state register, 2 bits):
  - IDLE: on divE, assert div_start for that cycle, then go to BUSY and clear the counter.
  - BUSY: div_busy = 1 and the counter increments each cycle.
    - On div_done, go to DONE.
    - Else, when the counter reaches DIV_MAX_CYCLES - 1, set div_err (sticky) and go to DONE. This releases the pipeline rather than deadlocking.
  - DONE: one cycle. No stall, no div_start, even though divE is still high (the result is written to HI/LO this cycle). Return to IDLE.
  - A new divE arriving the cycle after DONE starts a new division; back-to-back divides are legal.
- div_done while in IDLE or DONE is ignored.
- Reset (synchronous, overrides everything, takes effect even mid-division):
  - state = IDLE, counter = 0, div_err = 0.
  - All outputs then follow their combinational rules; with all inputs low every output is 0.
- Latency:
  - Forwarding, stall and flush are same-cycle combinational.
  - div_start is combinational from divE in IDLE.
  - The state changes on the next edge.

Decomposition:
- Shared package / header: FSM state encodings (IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10) and forward-select constants (FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10).
- One natural sub-module, div_handshake: FSM, watchdog counter, div_start / div_busy / div_err / divstall.
- Forwarding and load/branch stall logic stay in the top level.

Test Plan:
- Forwarding priority:
  - Stimulus: rsE = 5, regwriteM = 1, writeregM = 5, regwriteW = 1, writeregW = 5.
  - Expect forwardaE = 10.
  - Then drop regwriteM: expect forwardaE = 01.
  - Then set rsE = 0 with writeregM = 0: expect 00.
- Load-use:
  - Stimulus: memtoregE = 1, rtE = 8, rsD = 8.
  - Expect stallF = stallD = 1, flushE = 1, stallE = 0.
  - With rsD = rtD = 9: all four outputs 0.
- Branch hazard:
  - Stimulus: branchD = 1, rtD = 3, regwriteE = 1, writeregE = 3: expect stallD = 1, flushE = 1.
  - Same with jrD = 1 instead of branchD (rtD match only): expect no stall.
  - jrD = 1, memtoregM = 1, writeregM = rsD = 4: expect stall.
- Divide handshake:
  - Stimulus: divE held high; div_done pulses 10 cycles after div_start.
  - Expect div_start high for exactly 1 cycle, then stallE = flushM = 1 for 11 cycles total.
  - Expect a DONE cycle with all stalls 0 and no second div_start, then IDLE.
- Watchdog:
  - Stimulus: divE high, div_done never arrives.
  - Expect div_err = 1 after DIV_MAX_CYCLES cycles in BUSY, then a DONE cycle releasing the stall.
  - div_err stays 1 until rst.
- Reset mid-division:
  - Stimulus: assert rst in the 5th BUSY cycle.
  - Expect the next cycle to be IDLE with div_busy = 0 and div_err = 0.
  - A later div_done must not cause any state change.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: divider handshake states and
// forwarding mux selects.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // $0 is hardwired to zero, so it never produces a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_div_handshake.sv
// Start/done handshake with the multi-cycle divider, including a watchdog
// that releases the pipeline if the divider never answers.
//
//   state | meaning
//   IDLE  | no division in flight; divE fires div_start and stalls this cycle
//   BUSY  | waiting for div_done; pipeline frozen, watchdog counting
//   DONE  | result written to HI/LO this cycle; no stall, no restart
module div_handshake
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_MAX_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic div_e,
    input  logic div_done,
    output logic div_start,
    output logic div_busy,
    output logic div_err,
    output logic div_stall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MAX_CYCLES - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        div_start = 1'b0;
        div_busy  = 1'b0;
        div_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_e) begin
                    div_start = 1'b1;
                    div_stall = 1'b1;
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                div_busy  = 1'b1;
                div_stall = 1'b1;
                if (div_done) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Give up rather than deadlock the pipeline; error stays sticky.
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign div_err = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and stall/flush controller for the 5-stage MIPS core.
// Forwarding and load/branch stalls are combinational; divider sequencing lives in div_handshake.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_MAX_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       jrD,
    input  logic       divE,
    input  logic       div_done,
    output logic       forwardaD,
    output logic       forwardbD,
    output logic [1:0] forwardaE,
    output logic [1:0] forwardbE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushE,
    output logic       flushM,
    output logic       div_start,
    output logic       div_busy,
    output logic       div_err
);

    logic lw_stall;
    logic br_stall;
    logic div_stall;
    logic br_dep_e;
    logic br_dep_m;

    div_handshake #(
        .DIV_MAX_CYCLES(DIV_MAX_CYCLES),
        .CNT_W         (CNT_W)
    ) u_div_handshake (
        .clk      (clk),
        .rst      (rst),
        .div_e    (divE),
        .div_done (div_done),
        .div_start(div_start),
        .div_busy (div_busy),
        .div_err  (div_err),
        .div_stall(div_stall)
    );

    always_comb begin
        forwardaE = FWD_RF;
        if (regwriteM && reg_match(writeregM, rsE)) begin
            forwardaE = FWD_M;
        end else if (regwriteW && reg_match(writeregW, rsE)) begin
            forwardaE = FWD_W;
        end

        forwardbE = FWD_RF;
        if (regwriteM && reg_match(writeregM, rtE)) begin
            forwardbE = FWD_M;
        end else if (regwriteW && reg_match(writeregW, rtE)) begin
            forwardbE = FWD_W;
        end
    end

    assign forwardaD = regwriteM && reg_match(writeregM, rsD);
    assign forwardbD = regwriteM && reg_match(writeregM, rtD);

    assign lw_stall = memtoregE && (reg_match(rtE, rsD) || reg_match(rtE, rtD));

    // jr only reads rs, so rt dependencies only matter for branches.
    assign br_dep_e = regwriteE &&
                      (reg_match(writeregE, rsD) || (branchD && reg_match(writeregE, rtD)));
    assign br_dep_m = memtoregM &&
                      (reg_match(writeregM, rsD) || (branchD && reg_match(writeregM, rtD)));
    assign br_stall = (branchD || jrD) && (br_dep_e || br_dep_m);

    assign stallF = lw_stall | br_stall | div_stall;
    assign stallD = stallF;
    assign stallE = div_stall;
    // A held ID-EX must keep its instruction, so the divider stall wins over the bubble.
    assign flushE = (lw_stall | br_stall) & ~div_stall;
    assign flushM = div_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: expected output vectors are queued when
// inputs are driven and compared against the DUT half a cycle later.
module tb_hazard_ctrl;

    localparam int MAXC = 40;

    logic       clk;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, jrD, divE, div_done;
    logic       forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic       stallF, stallD, stallE, flushE, flushM;
    logic       div_start, div_busy, div_err;

    hazard_ctrl #(.DIV_MAX_CYCLES(MAXC), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jrD(jrD), .divE(divE), .div_done(div_done),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushE(flushE), .flushM(flushM),
        .div_start(div_start), .div_busy(div_busy), .div_err(div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Vector bits: [13]faD [12]fbD [11:10]faE [9:8]fbE [7]stallF [6]stallD
    // [5]stallE [4]flushE [3]flushM [2]div_start [1]div_busy [0]div_err
    logic [13:0] exp_q[$];
    string       tag_q[$];
    logic [13:0] obs_last;

    // bench-side divider model: 0 idle, 1 busy, 2 done
    int m_st  = 0;
    int m_cnt = 0;
    bit m_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic bit dep(input logic [4:0] d, input logic [4:0] s);
        return (d != 0) && (d == s);
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] src);
        if (regwriteM && dep(writeregM, src)) return 2'b10;
        if (regwriteW && dep(writeregW, src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [13:0] model_out();
        bit lw, br, ds, st;
        lw = memtoregE && (dep(rtE, rsD) || dep(rtE, rtD));
        br = (branchD || jrD) &&
             ((regwriteE && (dep(writeregE, rsD) || (branchD && dep(writeregE, rtD)))) ||
              (memtoregM && (dep(writeregM, rsD) || (branchD && dep(writeregM, rtD)))));
        ds = (m_st == 0 && divE) || (m_st == 1);
        st = lw || br || ds;
        return {regwriteM && dep(writeregM, rsD), regwriteM && dep(writeregM, rtD),
                fwd_e(rsE), fwd_e(rtE), st, st, ds, (lw || br) && !ds, ds,
                (m_st == 0 && divE), (m_st == 1), m_err};
    endfunction

    task automatic model_clock();
        if (rst) begin
            m_st = 0; m_cnt = 0; m_err = 0;
        end else begin
            case (m_st)
                0: if (divE) begin m_st = 1; m_cnt = 0; end
                1: begin
                    if (div_done) m_st = 2;
                    else if (m_cnt == MAXC - 1) begin m_err = 1; m_st = 2; end
                    else m_cnt++;
                end
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic step(input string tag);
        logic [13:0] e;
        string t;
        exp_q.push_back(model_out());
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        obs_last = {forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, stallE,
                    flushE, flushM, div_start, div_busy, div_err};
        check(t, 32'(obs_last), 32'(e));
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0;
        branchD = 0; jrD = 0; divE = 0; div_done = 0;
    endtask

    initial begin
        int start_cnt, stall_cnt, busy_cnt;
        bit found;

        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("reset");
        check("reset_all_zero", 32'(obs_last), 32'd0);
        rst = 1'b0;

        // forwarding priority
        rsE = 5; regwriteM = 1; writeregM = 5; regwriteW = 1; writeregW = 5;
        step("fwd_m_prio");
        check("fwdaE_m", 32'(obs_last[11:10]), 32'h2);
        regwriteM = 0;
        step("fwd_w");
        check("fwdaE_w", 32'(obs_last[11:10]), 32'h1);
        rsE = 0; writeregM = 0; regwriteM = 1;
        step("fwd_zero_reg");
        check("fwdaE_rf", 32'(obs_last[11:10]), 32'h0);
        rtE = 7; writeregW = 7; rsD = 6; rtD = 6; writeregM = 6;
        step("fwd_b_and_d");
        check("fwdD_both", 32'(obs_last[13:12]), 32'h3);
        clear_inputs();

        // load-use
        memtoregE = 1; rtE = 8; rsD = 8;
        step("lw_stall");
        check("lw_stall_bits", 32'({obs_last[7:4]}), 32'b1101);
        rsD = 9; rtD = 9;
        step("lw_nodep");
        check("lw_nodep_bits", 32'({obs_last[7:4]}), 32'b0000);
        clear_inputs();

        // branch hazards
        branchD = 1; rtD = 3; regwriteE = 1; writeregE = 3;
        step("br_rt_e");
        check("br_rt_stall", 32'({obs_last[6], obs_last[4]}), 32'b11);
        branchD = 0; jrD = 1;
        step("jr_rt_ignored");
        check("jr_rt_nostall", 32'({obs_last[6], obs_last[4]}), 32'b00);
        regwriteE = 0; memtoregM = 1; writeregM = 4; rsD = 4;
        step("jr_rs_m");
        check("jr_m_stall", 32'(obs_last[6]), 32'd1);
        writeregM = 0; rsD = 0;
        step("jr_r0");
        check("jr_r0_nostall", 32'(obs_last[6]), 32'd0);
        clear_inputs();

        // divide handshake, div_done ten cycles after div_start
        divE = 1; start_cnt = 0; stall_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            div_done = (i == 10);
            step("div_seq");
            start_cnt += int'(obs_last[2]);
            stall_cnt += int'(obs_last[5] & obs_last[3]);
        end
        div_done = 0;
        check("div_start_pulses", 32'(start_cnt), 32'd1);
        check("div_stall_cycles", 32'(stall_cnt), 32'd11);
        check("div_done_release", 32'(obs_last[7:2]), 32'd0);

        // back-to-back divide, then the divider never answers
        step("div_b2b_start");
        check("b2b_start", 32'(obs_last[2]), 32'd1);
        busy_cnt = 0; found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            step("wdog");
            if (obs_last[0]) found = 1;
            else busy_cnt += int'(obs_last[1]);
        end
        check("wdog_fired", 32'(found), 32'd1);
        check("wdog_busy_cycles", 32'(busy_cnt), 32'(MAXC));
        check("wdog_release", 32'(obs_last[7:2]), 32'd0);
        divE = 0;
        for (int k = 0; k < 3; k++) step("err_sticky");
        check("err_sticky", 32'(obs_last[0]), 32'd1);

        // reset in the fifth BUSY cycle
        divE = 1;
        step("rst_div_start");
        for (int k = 0; k < 4; k++) step("rst_div_busy");
        rst = 1; divE = 0;
        step("rst_mid_div");
        rst = 0;
        step("after_rst");
        check("after_rst_idle", 32'(obs_last[1:0]), 32'd0);
        div_done = 1;
        step("stray_done");
        div_done = 0;
        step("stray_done_after");
        check("stray_done_idle", 32'(obs_last[5:0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
